// File: rtl/keypad_scan_ctrl.sv
// Keypad scanner: sequences a 12-channel key mux, debounces each channel and queues
// press codes in a small FIFO drained through a valid/ready handshake.
module keypad_scan_ctrl #(
  parameter int unsigned DWELL      = 2,
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        key_in_i,
  output logic [3:0]  sel_o,
  output logic [3:0]  key_code_o,
  output logic        key_valid_o,
  input  logic        key_ready_i,
  output logic [11:0] key_held_o,
  output logic        overflow_o,
  input  logic        ovf_clr_i,
  output logic        scan_done_o
);

  localparam int unsigned NumCh = 12;
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;

  localparam logic [3:0]      LastCh    = 4'd11;
  localparam logic [3:0]      SettleEnd = 4'(DWELL - 2);
  localparam logic [3:0]      SampleCnt = 4'(DWELL - 1);
  localparam logic [3:0]      DebLast   = 4'(DEB_CYCLES - 1);
  localparam logic [CntW-1:0] FullCnt   = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StSettle, StSample} state_e;

  state_e           state_q, state_d;
  logic [3:0]       dwell_q, dwell_d;
  logic [3:0]       sel_q, sel_d;
  logic [3:0]       deb_cnt_q [NumCh];
  logic [3:0]       deb_cnt_d [NumCh];
  logic [11:0]      key_held_q, key_held_d;
  logic [3:0]       mem_q [FIFO_DEPTH];
  logic [3:0]       mem_d [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             overflow_q, overflow_d;
  logic             scan_done_q, scan_done_d;

  logic sample, wrap, push, push_ok, pop, drop;

  // Scan sequencer: enable low always parks in idle and discards the partial dwell.
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    sel_d   = sel_q;
    sample  = 1'b0;
    wrap    = 1'b0;
    if (!enable_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StSettle;
          dwell_d = '0;
        end
        StSettle: begin
          if (dwell_q == SettleEnd) begin
            state_d = StSample;
            dwell_d = SampleCnt;
          end else begin
            dwell_d = dwell_q + 4'd1;
          end
        end
        StSample: begin
          sample  = 1'b1;
          state_d = StSettle;
          dwell_d = '0;
          if (sel_q == LastCh) begin
            sel_d = '0;
            wrap  = 1'b1;
          end else begin
            sel_d = sel_q + 4'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    deb_cnt_d  = deb_cnt_q;
    key_held_d = key_held_q;
    push       = 1'b0;
    if (sample) begin
      if (key_in_i == key_held_q[sel_q]) begin
        deb_cnt_d[sel_q] = '0;
      end else if (deb_cnt_q[sel_q] == DebLast) begin
        key_held_d[sel_q] = ~key_held_q[sel_q];
        deb_cnt_d[sel_q]  = '0;
        push              = ~key_held_q[sel_q];
      end else begin
        deb_cnt_d[sel_q] = deb_cnt_q[sel_q] + 4'd1;
      end
    end
  end

  // A pop in the same cycle frees a slot, so a push into a full queue still lands.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop      = key_valid_q & key_ready_i;
    push_ok  = push & ((count_q != FullCnt) | pop);
    drop     = push & ~push_ok;
    if (push_ok) begin
      mem_d[wr_ptr_q] = sel_q;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    key_valid_d = (count_d != '0);
    key_code_d  = key_valid_d ? mem_d[rd_ptr_d] : key_code_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr_i) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    scan_done_d = wrap;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      dwell_q     <= '0;
      sel_q       <= '0;
      deb_cnt_q   <= '{default: '0};
      key_held_q  <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      sel_q       <= sel_d;
      deb_cnt_q   <= deb_cnt_d;
      key_held_q  <= key_held_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      overflow_q  <= overflow_d;
      scan_done_q <= scan_done_d;
    end
  end

  assign sel_o       = sel_q;
  assign key_code_o  = key_code_q;
  assign key_valid_o = key_valid_q;
  assign key_held_o  = key_held_q;
  assign overflow_o  = overflow_q;
  assign scan_done_o = scan_done_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: wrap table, directed corner sequences and random traffic,
// all checked against a scan-time based reference model.
module tb_keypad_scan_ctrl;

  localparam int DWELL = 2;
  localparam int DEB   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, enable, key_in, key_ready, ovf_clr;
  logic [3:0]  sel, key_code;
  logic        key_valid, overflow, scan_done;
  logic [11:0] key_held;

  keypad_scan_ctrl #(
    .DWELL      (DWELL),
    .DEB_CYCLES (DEB),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .enable_i    (enable),
    .key_in_i    (key_in),
    .sel_o       (sel),
    .key_code_o  (key_code),
    .key_valid_o (key_valid),
    .key_ready_i (key_ready),
    .key_held_o  (key_held),
    .overflow_o  (overflow),
    .ovf_clr_i   (ovf_clr),
    .scan_done_o (scan_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: position in the scan measured in clocks, not FSM states.
  int          m_t;
  bit          m_active;
  int          m_cnt [12];
  bit   [11:0] m_held;
  int          q[$];
  logic [3:0]  m_code;
  bit          m_ovf, m_done;
  bit   [11:0] pmask;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic m_step(input bit en, input bit kin, input bit rdy, input bit clr,
                        input bit r);
    bit pop;
    bit drop;
    int push_c;
    int ch;
    if (r) begin
      m_t = 0; m_active = 0; m_cnt = '{default: 0}; m_held = '0;
      q.delete(); m_code = '0; m_ovf = 0; m_done = 0;
      return;
    end
    pop    = (q.size() != 0) && rdy;
    push_c = -1;
    drop   = 0;
    m_done = 0;
    if (!en) begin
      m_t      = m_t - (m_t % DWELL);
      m_active = 0;
    end else if (!m_active) begin
      m_active = 1;
    end else begin
      ch = m_t / DWELL;
      if (m_t % DWELL == DWELL - 1) begin
        if (kin == m_held[ch]) m_cnt[ch] = 0;
        else if (m_cnt[ch] == DEB - 1) begin
          m_cnt[ch]  = 0;
          m_held[ch] = kin;
          if (kin) push_c = ch;
        end else m_cnt[ch]++;
        if (ch == 11) m_done = 1;
      end
      m_t = (m_t + 1) % (12 * DWELL);
    end
    if (pop) void'(q.pop_front());
    if (push_c >= 0) begin
      if (q.size() < DEPTH) q.push_back(push_c);
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (q.size() != 0) m_code = 4'(q[0]);
  endtask

  task automatic step(input bit en, input bit kin, input bit rdy, input bit clr, input bit r);
    logic [22:0] act, exp;
    enable = en; key_in = kin; key_ready = rdy; ovf_clr = clr; rst = r;
    @(posedge clk);
    m_step(en, kin, rdy, clr, r);
    #1;
    act = {sel, key_code, key_valid, key_held, overflow, scan_done};
    exp = {4'(m_t / DWELL), m_code, 1'(q.size() != 0), m_held, m_ovf, m_done};
    chk("model", 32'(act), 32'(exp));
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1, pmask[m_t / DWELL], rdy, 0, 0);
  endtask

  task automatic press_release(input int c);
    pmask = 12'(1 << c);
    run(5 * 24, 0);
    pmask = '0;
    run(5 * 24, 0);
  endtask

  typedef struct {
    bit         en;
    logic [3:0] exp_sel;
    bit         exp_done;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int   cnt;
    int   ch;
    bit   found;
    int   exp_pops [4];
    rst = 1; enable = 0; key_in = 0; key_ready = 0; ovf_clr = 0;
    pmask = '0;

    for (int i = 0; i < 50; i++) begin
      v.en = 1; v.exp_sel = 4'((i / 2) % 12); v.exp_done = (i % 24 == 0) && (i > 0);
      vecs.push_back(v);
    end
    v.en = 0; v.exp_sel = 4'd0; v.exp_done = 0; vecs.push_back(v);
    v.en = 1; v.exp_sel = 4'd0; v.exp_done = 0; vecs.push_back(v);
    v.en = 1; v.exp_sel = 4'd0; v.exp_done = 0; vecs.push_back(v);
    v.en = 1; v.exp_sel = 4'd1; v.exp_done = 0; vecs.push_back(v);

    // Reset state
    do_reset();
    chk("rst_sel", 32'(sel), 0);
    chk("rst_valid", 32'(key_valid), 0);
    chk("rst_code", 32'(key_code), 0);
    chk("rst_held", 32'(key_held), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_done", 32'(scan_done), 0);

    // Wrap table
    foreach (vecs[i]) begin
      step(vecs[i].en, 0, 0, 0, 0);
      chk("wrap_sel", 32'(sel), 32'(vecs[i].exp_sel));
      chk("wrap_done", 32'(scan_done), 32'(vecs[i].exp_done));
      chk("wrap_valid", 32'(key_valid), 0);
    end

    // Clean press on channel 5: held/valid change after the sample in cycle 83
    do_reset();
    step(1, 0, 0, 0, 0);
    for (int t = 0; t < 84; t++) begin
      step(1, ((t / 2) % 12) == 5, 0, 0, 0);
      if (t == 82) begin
        chk("press_early_valid", 32'(key_valid), 0);
        chk("press_early_held", 32'(key_held[5]), 0);
      end
    end
    chk("press_valid", 32'(key_valid), 1);
    chk("press_code", 32'(key_code), 5);
    chk("press_held", 32'(key_held), 32'h020);
    pmask = 12'h020;
    run(48, 0);
    step(1, pmask[m_t / DWELL], 1, 0, 0);
    chk("press_single_entry", 32'(key_valid), 0);

    // Bounce on channel 7, then press and sustained release
    do_reset();
    for (int s = 0; s < 8; s++) begin
      pmask = (s % 2 == 0) ? 12'h080 : 12'h000;
      run(24, 0);
    end
    chk("bounce_held", 32'(key_held[7]), 0);
    chk("bounce_valid", 32'(key_valid), 0);
    pmask = 12'h080;
    run(5 * 24, 0);
    chk("bounce_press_code", 32'(key_code), 7);
    step(1, pmask[m_t / DWELL], 1, 0, 0);
    pmask = '0;
    run(5 * 24, 0);
    chk("release_held", 32'(key_held[7]), 0);
    chk("release_valid", 32'(key_valid), 0);

    // Overflow: fifth press is dropped
    do_reset();
    press_release(1); press_release(2); press_release(3);
    press_release(10); press_release(11);
    chk("ovf_set", 32'(overflow), 1);
    exp_pops = '{1, 2, 3, 10};
    for (int i = 0; i < 4; i++) begin
      chk("ovf_pop_code", 32'(key_code), 32'(exp_pops[i]));
      step(1, 0, 1, 0, 0);
    end
    chk("ovf_drained", 32'(key_valid), 0);
    step(1, 0, 0, 1, 0);
    chk("ovf_clr", 32'(overflow), 0);

    // Full queue with a pop in the same cycle as a new push
    do_reset();
    press_release(1); press_release(2); press_release(3); press_release(4);
    chk("full_no_ovf", 32'(overflow), 0);
    pmask = 12'h001;
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      if (m_active && (m_t % DWELL == DWELL - 1) && (m_t / DWELL == 0) &&
          (m_cnt[0] == DEB - 1) && !m_held[0]) found = 1;
      else step(1, pmask[m_t / DWELL], 0, 0, 0);
    end
    chk("full_pop_found", 32'(found), 1);
    step(1, 1, 1, 0, 0);
    chk("full_pop_ovf", 32'(overflow), 0);
    pmask = '0;
    exp_pops = '{2, 3, 4, 0};
    for (int i = 0; i < 4; i++) begin
      chk("full_pop_code", 32'(key_code), 32'(exp_pops[i]));
      step(1, 0, 1, 0, 0);
    end
    chk("full_drained", 32'(key_valid), 0);

    // Enable drop mid-settle at channel 6, then reset with entries queued
    do_reset();
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step(1, 0, 0, 0, 0);
      if (m_active && m_t == 12) found = 1;
    end
    chk("en_found", 32'(found), 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      chk("en_hold_sel", 32'(sel), 6);
    end
    step(1, 0, 0, 0, 0);
    chk("reen_settle_sel", 32'(sel), 6);
    step(1, 0, 0, 0, 0);
    chk("reen_sample_sel", 32'(sel), 6);
    step(1, 0, 0, 0, 0);
    chk("reen_next_sel", 32'(sel), 7);
    pmask = 12'h004;
    run(5 * 24, 0);
    pmask = 12'h008;
    run(5 * 24, 0);
    chk("pre_rst_valid", 32'(key_valid), 1);
    step(1, 1, 0, 0, 1);
    chk("mid_rst_valid", 32'(key_valid), 0);
    chk("mid_rst_sel", 32'(sel), 0);
    chk("mid_rst_held", 32'(key_held), 0);
    chk("mid_rst_ovf", 32'(overflow), 0);

    // Random traffic against the model
    pmask = '0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        ch = $urandom_range(0, 11);
        pmask[ch] = ~pmask[ch];
      end
      cnt = m_t / DWELL;
      step($urandom_range(0, 19) != 0,
           pmask[cnt] ^ ($urandom_range(0, 19) == 0),
           $urandom_range(0, 9) < 3,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 999) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
